// File: rtl/cdb_arbiter_if.sv
// Bus bundle for the CDB arbiter: per-source result handshake plus the broadcast side.
// The master modport is the functional-unit/consumer side; the slave modport is the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic                      busy;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, busy
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus producer: one FIFO per functional unit, round-robin drain, one broadcast per cycle.
// Define CDB_REG_OUT_EN to register the broadcast outputs (two-cycle latency instead of one).
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8,
  parameter int DATA_W     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W:0]   NSRC     = (SRC_W+1)'(NUM_SRC);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  logic [TAG_W-1:0]  tag_mem  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
  logic [CNT_W-1:0]  cnt      [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  rr_next;

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] wr_en;
  logic [NUM_SRC-1:0] rd_en;

  logic              found;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W:0]    cand;
  logic              pop;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_data;

  // Ready depends only on stored count, so a full FIFO refuses a push even while it is popped.
  always_comb begin
    full     = '0;
    nonempty = '0;
    ready    = '0;
    push     = '0;
    wr_en    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      full[i]     = (cnt[i] == FULL_CNT);
      nonempty[i] = (cnt[i] != '0);
      ready[i]    = en && !reset && !full[i];
      push[i]     = bus.src_valid[i] && ready[i];
      wr_en[i]    = push[i] && (bus.src_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  assign bus.src_ready = ready;

  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand >= NSRC) cand = cand - NSRC;
      if (!found && nonempty[cand[SRC_W-1:0]]) begin
        found = 1'b1;
        grant = cand[SRC_W-1:0];
      end
    end
  end

  assign pop       = en && !reset && found;
  assign head_tag  = tag_mem[grant][rd_ptr[grant]];
  assign head_data = data_mem[grant][rd_ptr[grant]];
  assign rr_next   = (grant == LAST_SRC) ? '0 : grant + 1'b1;

  always_comb begin
    rd_en = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rd_en[i] = pop && (grant == SRC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      if (pop) rr_ptr <= rr_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (wr_en[i] && !rd_en[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!wr_en[i] && rd_en[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_en[i]) begin
        tag_mem[i][wr_ptr[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
        data_mem[i][wr_ptr[i]] <= bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CDB_REG_OUT_EN
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;

  always_ff @(posedge clk) begin
    if (reset || !pop) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b1;
      out_tag   <= head_tag;
      out_data  <= head_data;
    end
  end

  assign bus.cdb_valid = out_valid && !reset;
  assign bus.cdb_tag   = (out_valid && !reset) ? out_tag  : '0;
  assign bus.cdb_data  = (out_valid && !reset) ? out_data : '0;
  assign bus.busy      = !reset && ((|nonempty) || out_valid);
`else
  assign bus.cdb_valid = pop;
  assign bus.cdb_tag   = pop ? head_tag  : '0;
  assign bus.cdb_data  = pop ? head_data : '0;
  assign bus.busy      = !reset && (|nonempty);
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: accepted results go into a scoreboard queue and are
// matched against every broadcast; scenario tasks add inline latency/ordering/ready checks.
module tb_cdb_arbiter;
  localparam int NS = 4;
  localparam int TW = 8;
  localparam int DW = 32;
`ifdef CDB_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [2:0]    src;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  int checks = 0;
  int errors = 0;
  ent_t exp_q[$];
  int acc[NS];
  int bcast[NS];
  int nb = 0;
  int last_src = -1;
  int hit;
  bit older;
  ent_t e;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(4), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  // Accepted, non-zero-tag pushes become expected broadcasts; reset discards them.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (bus.src_valid[i] && bus.src_ready[i] && bus.src_tag[i*TW +: TW] != '0) begin
          e.src  = 3'(i);
          e.tag  = bus.src_tag[i*TW +: TW];
          e.data = bus.src_data[i*DW +: DW];
          exp_q.push_back(e);
          acc[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    last_src = -1;
    if (bus.cdb_valid === 1'b1) begin
      hit = -1;
      foreach (exp_q[j]) if (hit < 0 && exp_q[j].tag == bus.cdb_tag) hit = j;
      if (hit < 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got tag %0d data %h, no such result pending", bus.cdb_tag, bus.cdb_data);
      end else begin
        older = 1'b0;
        for (int j = 0; j < hit; j++) if (exp_q[j].src == exp_q[hit].src) older = 1'b1;
        if (older || exp_q[hit].data !== bus.cdb_data) begin
          errors++;
          $display("FAIL cdb_order_data: tag %0d got data %h exp %h, older entry of same source pending=%0d",
                   bus.cdb_tag, bus.cdb_data, exp_q[hit].data, older);
        end
        last_src = int'(exp_q[hit].src);
        bcast[last_src]++;
        nb++;
        exp_q.delete(hit);
      end
    end else if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== '0 || bus.cdb_data !== '0) begin
      errors++;
      $display("FAIL cdb_idle: got valid %b tag %h data %h, exp 0/0/0", bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.src_valid[i]        = v;
    bus.src_tag[i*TW +: TW] = t;
    bus.src_data[i*DW +: DW] = d;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NS; i++) set_src(i, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 8'(i + 1), 32'h1000 + i);
    cyc();
    cyc();
    @(negedge clk); #1;
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== '0 || bus.cdb_data !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b tag %h data %h busy %b, exp all 0",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.busy);
    end
    checks++;
    if (bus.src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b exp 0000", bus.src_ready);
    end
    cyc();
    reset = 1'b0;
    clear_src();
    @(negedge clk); #1;
    checks++;
    if (bus.src_ready !== 4'b1111 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready %b busy %b exp 1111/0", bus.src_ready, bus.busy);
    end
  endtask

  task automatic test_single_push();
    cyc();
    set_src(0, 1'b1, 8'd5, 32'hDEAD);
    cyc();
    clear_src();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.cdb_valid !== (c == LAT) || (c == LAT && bus.cdb_tag !== 8'd5)) begin
        errors++;
        $display("FAIL single_push c%0d: got valid %b tag %0d exp valid %0d tag 5", c, bus.cdb_valid, bus.cdb_tag, c == LAT);
      end
      checks++;
      if (bus.busy !== (c <= LAT)) begin
        errors++;
        $display("FAIL single_busy c%0d: got %b exp %0d", c, bus.busy, c <= LAT);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] exp_tag;
    do_reset();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 8'(i + 1), 32'h100 + i);
    cyc();
    clear_src();
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk); #1;
      exp_tag = (c >= LAT) ? 8'(c - LAT + 1) : 8'd0;
      checks++;
      if (bus.cdb_tag !== exp_tag) begin
        errors++;
        $display("FAIL rr_order c%0d: got tag %0d exp %0d", c, bus.cdb_tag, exp_tag);
      end
    end
    cyc();
    set_src(0, 1'b1, 8'd21, 32'h2100);
    set_src(1, 1'b1, 8'd22, 32'h2200);
    cyc();
    clear_src();
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk); #1;
      exp_tag = (c == LAT) ? 8'd21 : (c == LAT + 1) ? 8'd22 : 8'd0;
      checks++;
      if (bus.cdb_tag !== exp_tag) begin
        errors++;
        $display("FAIL rr_wrap c%0d: got tag %0d exp %0d", c, bus.cdb_tag, exp_tag);
      end
    end
  endtask

  task automatic test_backpressure();
    int a_start[NS];
    int b2_start, n2, cnt2, popped2;
    bit saw_full, done;
    cyc();
    en = 1'b0;
    set_src(2, 1'b1, 8'd10, 32'hA00);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.src_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready_en0: got %b exp 0000", bus.src_ready);
      end
    end
    cyc();
    en = 1'b1;
    for (int i = 0; i < NS; i++) a_start[i] = acc[i];
    b2_start = bcast[2];
    saw_full = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      n2 = acc[2] - a_start[2];
      if (n2 >= 6) begin
        done = 1'b1;
      end else begin
        set_src(2, 1'b1, 8'(10 + n2), 32'hA00 + 32'(n2));
        set_src(0, 1'b1, 8'(8'h40 + acc[0] - a_start[0]), 32'h4000 + 32'(acc[0]));
        set_src(1, 1'b1, 8'(8'h80 + acc[1] - a_start[1]), 32'h8000 + 32'(acc[1]));
        set_src(3, 1'b1, 8'(8'hC0 + acc[3] - a_start[3]), 32'hC000 + 32'(acc[3]));
        @(negedge clk); #1;
        popped2 = bcast[2] - b2_start - ((LAT == 1 && last_src == 2) ? 1 : 0);
        cnt2 = n2 - popped2;
        checks++;
        if (bus.src_ready[2] !== (cnt2 != 4)) begin
          errors++;
          $display("FAIL bp_ready2: got %b exp %0d with %0d entries queued", bus.src_ready[2], cnt2 != 4, cnt2);
        end
        if (cnt2 == 4) saw_full = 1'b1;
        cyc();
      end
    end
    clear_src();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_timeout: got %0d of 6 src2 results accepted, exp 6", acc[2] - a_start[2]);
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL bp_full: got no cycle with src2 holding 4 entries, exp at least one");
    end
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (bus.busy === 1'b0 && exp_q.size() == 0) break;
    end
    checks++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got busy %b pending %0d, exp 0/0", bus.busy, exp_q.size());
    end
  endtask

  task automatic test_tag_zero();
    int nb0;
    logic [TW-1:0] exp_tag;
    cyc();
    set_src(1, 1'b1, 8'd0, 32'hBAD0);
    cyc();
    set_src(1, 1'b1, 8'd7, 32'h77);
    nb0 = nb;
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL tag0_dropped: got busy %b valid %b, exp 0/0", bus.busy, bus.cdb_valid);
    end
    cyc();
    clear_src();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      exp_tag = (c == LAT) ? 8'd7 : 8'd0;
      checks++;
      if (bus.cdb_tag !== exp_tag || bus.cdb_valid !== (c == LAT)) begin
        errors++;
        $display("FAIL tag0_bcast c%0d: got valid %b tag %0d exp tag %0d", c, bus.cdb_valid, bus.cdb_tag, exp_tag);
      end
    end
    checks++;
    if (nb - nb0 != 1) begin
      errors++;
      $display("FAIL tag0_count: got %0d broadcasts exp 1", nb - nb0);
    end
  endtask

  task automatic test_reset_mid_op();
    int nb0;
    logic [TW-1:0] exp_tag;
    cyc();
    set_src(0, 1'b1, 8'd31, 32'h31);
    set_src(1, 1'b1, 8'd32, 32'h32);
    set_src(2, 1'b1, 8'd33, 32'h33);
    cyc();
    clear_src();
    reset = 1'b1;
    nb0 = nb;
    @(negedge clk); #1;
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== '0 || bus.cdb_data !== '0 ||
        bus.busy !== 1'b0 || bus.src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid %b tag %h busy %b ready %b, exp all 0",
               bus.cdb_valid, bus.cdb_tag, bus.busy, bus.src_ready);
    end
    cyc();
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.cdb_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_discard c%0d: got valid %b busy %b exp 0/0", c, bus.cdb_valid, bus.busy);
      end
    end
    checks++;
    if (nb != nb0) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d broadcasts exp 0", nb - nb0);
    end
    cyc();
    set_src(0, 1'b1, 8'd41, 32'h41);
    set_src(3, 1'b1, 8'd44, 32'h44);
    cyc();
    clear_src();
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk); #1;
      exp_tag = (c == LAT) ? 8'd41 : (c == LAT + 1) ? 8'd44 : 8'd0;
      checks++;
      if (bus.cdb_tag !== exp_tag) begin
        errors++;
        $display("FAIL rst_mid_rr c%0d: got tag %0d exp %0d", c, bus.cdb_tag, exp_tag);
      end
    end
  endtask

  task automatic test_stall();
    logic [TW-1:0] exp_tag;
    cyc();
    set_src(1, 1'b1, 8'd51, 32'h5151);
    set_src(2, 1'b1, 8'd52, 32'h5252);
    cyc();
    clear_src();
    en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== '0 || bus.busy !== 1'b1 || bus.src_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall c%0d: got valid %b tag %0d busy %b ready %b, exp 0/0/1/0000",
                 c, bus.cdb_valid, bus.cdb_tag, bus.busy, bus.src_ready);
      end
    end
    cyc();
    en = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk); #1;
      exp_tag = (c == LAT) ? 8'd51 : (c == LAT + 1) ? 8'd52 : 8'd0;
      checks++;
      if (bus.cdb_tag !== exp_tag) begin
        errors++;
        $display("FAIL stall_resume c%0d: got tag %0d exp %0d", c, bus.cdb_tag, exp_tag);
      end
    end
  endtask

  initial begin
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_data  = '0;
    for (int i = 0; i < NS; i++) begin
      acc[i]   = 0;
      bcast[i] = 0;
    end
    test_reset();
    test_single_push();
    test_round_robin();
    test_backpressure();
    test_tag_zero();
    test_reset_mid_op();
    test_stall();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); #1;
      if (bus.busy === 1'b0 && exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL final_drain: got %0d results never broadcast, busy %b, exp 0/0", exp_q.size(), bus.busy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run by 100000 time units");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
